// File: rtl/rr_trace_buf_sched.sv
// Trace buffer scheduler: queues host buffer descriptors and hands them one at
// a time to a trace engine, strobing the record or replay load for each issue.
module rr_trace_buf_sched #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 64,
  parameter int SIZE_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         enable,
  input  logic                         mode,
  input  logic                         desc_valid,
  output logic                         desc_ready,
  input  logic [ADDR_WIDTH-1:0]        desc_addr,
  input  logic [SIZE_WIDTH-1:0]        desc_size,
  input  logic                         buf_done,
  output logic [ADDR_WIDTH-1:0]        buf_addr,
  output logic [SIZE_WIDTH-1:0]        buf_size,
  output logic                         write_buf_update,
  output logic                         read_buf_update,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
  output logic [31:0]                  bufs_done_cnt,
  output logic                         err_unexp_done,
  output logic                         err_zero_size
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARM    = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_DRAIN  = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q [DEPTH];
  logic [ADDR_WIDTH-1:0]   mem_addr_d [DEPTH];
  logic [SIZE_WIDTH-1:0]   mem_size_q [DEPTH];
  logic [SIZE_WIDTH-1:0]   mem_size_d [DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [ADDR_WIDTH-1:0]   buf_addr_q, buf_addr_d;
  logic [SIZE_WIDTH-1:0]   buf_size_q, buf_size_d;
  logic                    mode_q, mode_d;
  logic                    wr_upd_q, wr_upd_d;
  logic                    rd_upd_q, rd_upd_d;
  logic                    busy_q, busy_d;
  logic [31:0]             done_cnt_q, done_cnt_d;
  logic                    err_unexp_q, err_unexp_d;
  logic                    err_zero_q, err_zero_d;

  logic ready_s, push_s, pop_s, issue_s, discard_s;
  logic head_valid_s, head_zero_s, engine_done_s, stray_done_s;

  // Readiness comes from the registered count only, so a pop never widens the window early.
  assign ready_s       = (count_q < CNT_W'(DEPTH));
  assign push_s        = desc_valid && ready_s;
  assign head_valid_s  = (count_q != {CNT_W{1'b0}});
  assign head_zero_s   = (mem_size_q[rd_ptr_q] == {SIZE_WIDTH{1'b0}});
  assign pop_s         = issue_s || discard_s;
  assign engine_done_s = buf_done && ((state_q == ST_ACTIVE) || (state_q == ST_DRAIN));
  assign stray_done_s  = buf_done && ((state_q == ST_IDLE) || (state_q == ST_ARM));

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; zero-size heads are discarded ahead of any issue.
  always_comb begin
    state_d   = state_q;
    issue_s   = 1'b0;
    discard_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (head_valid_s && head_zero_s) begin
          discard_s = 1'b1;
        end else if (head_valid_s && enable) begin
          issue_s = 1'b1;
          state_d = ST_ARM;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ARM:    state_d = ST_ACTIVE;
      ST_ACTIVE: begin
        if (buf_done) begin
          state_d = ST_IDLE;
        end else if (!enable) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_ACTIVE;
        end
      end
      ST_DRAIN: begin
        if (buf_done) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output logic: strobes and busy are registered from the next state.
  always_comb begin
    wr_upd_d = (state_d == ST_ARM) && !mode_d;
    rd_upd_d = (state_d == ST_ARM) && mode_d;
    busy_d   = (state_d != ST_IDLE);
  end

  // FIFO storage, pointers, issued-buffer registers and status counters.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_addr_d[i] = mem_addr_q[i];
      mem_size_d[i] = mem_size_q[i];
    end
    if (push_s) begin
      mem_addr_d[wr_ptr_q] = desc_addr;
      mem_size_d[wr_ptr_q] = desc_size;
    end else begin
      mem_addr_d[wr_ptr_q] = mem_addr_q[wr_ptr_q];
      mem_size_d[wr_ptr_q] = mem_size_q[wr_ptr_q];
    end
    wr_ptr_d = push_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    rd_ptr_d = pop_s  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    buf_addr_d  = issue_s ? mem_addr_q[rd_ptr_q] : buf_addr_q;
    buf_size_d  = issue_s ? mem_size_q[rd_ptr_q] : buf_size_q;
    mode_d      = issue_s ? mode : mode_q;
    done_cnt_d  = engine_done_s ? (done_cnt_q + 32'd1) : done_cnt_q;
    err_unexp_d = err_unexp_q || stray_done_s;
    err_zero_d  = err_zero_q || discard_s;
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_addr_q[i] <= {ADDR_WIDTH{1'b0}};
        mem_size_q[i] <= {SIZE_WIDTH{1'b0}};
      end
      wr_ptr_q    <= {PTR_W{1'b0}};
      rd_ptr_q    <= {PTR_W{1'b0}};
      count_q     <= {CNT_W{1'b0}};
      buf_addr_q  <= {ADDR_WIDTH{1'b0}};
      buf_size_q  <= {SIZE_WIDTH{1'b0}};
      mode_q      <= 1'b0;
      wr_upd_q    <= 1'b0;
      rd_upd_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_cnt_q  <= 32'd0;
      err_unexp_q <= 1'b0;
      err_zero_q  <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_addr_q[i] <= mem_addr_d[i];
        mem_size_q[i] <= mem_size_d[i];
      end
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      buf_addr_q  <= buf_addr_d;
      buf_size_q  <= buf_size_d;
      mode_q      <= mode_d;
      wr_upd_q    <= wr_upd_d;
      rd_upd_q    <= rd_upd_d;
      busy_q      <= busy_d;
      done_cnt_q  <= done_cnt_d;
      err_unexp_q <= err_unexp_d;
      err_zero_q  <= err_zero_d;
    end
  end

  assign desc_ready       = ready_s;
  assign fifo_count       = count_q;
  assign buf_addr         = buf_addr_q;
  assign buf_size         = buf_size_q;
  assign write_buf_update = wr_upd_q;
  assign read_buf_update  = rd_upd_q;
  assign busy             = busy_q;
  assign bufs_done_cnt    = done_cnt_q;
  assign err_unexp_done   = err_unexp_q;
  assign err_zero_size    = err_zero_q;

endmodule

// File: tb/tb_rr_trace_buf_sched.sv
// Bench for rr_trace_buf_sched: directed vector table, corner-case sequences and
// randomized traffic, all checked against a queue-based reference model.
module tb_rr_trace_buf_sched;

  localparam int DEPTH = 4;
  localparam int P_IDLE = 0, P_ARM = 1, P_ACT = 2, P_DRAIN = 3;

  logic                         clk = 1'b0;
  logic                         rstn = 1'b0;
  logic                         enable = 1'b0, mode = 1'b0, desc_valid = 1'b0, buf_done = 1'b0;
  logic [63:0]                  desc_addr = 64'd0;
  logic [31:0]                  desc_size = 32'd0;
  logic                         desc_ready, write_buf_update, read_buf_update, busy;
  logic [63:0]                  buf_addr;
  logic [31:0]                  buf_size;
  logic [$clog2(DEPTH+1)-1:0]   fifo_count;
  logic [31:0]                  bufs_done_cnt;
  logic                         err_unexp_done, err_zero_size;

  rr_trace_buf_sched #(.DEPTH(DEPTH), .ADDR_WIDTH(64), .SIZE_WIDTH(32)) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .mode(mode),
    .desc_valid(desc_valid), .desc_ready(desc_ready),
    .desc_addr(desc_addr), .desc_size(desc_size), .buf_done(buf_done),
    .buf_addr(buf_addr), .buf_size(buf_size),
    .write_buf_update(write_buf_update), .read_buf_update(read_buf_update),
    .busy(busy), .fifo_count(fifo_count), .bufs_done_cnt(bufs_done_cnt),
    .err_unexp_done(err_unexp_done), .err_zero_size(err_zero_size)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed { logic [63:0] a; logic [31:0] s; } desc_t;
  desc_t       m_q[$];
  int          m_phase;
  logic [63:0] m_addr;
  logic [31:0] m_size;
  logic        m_mode, m_eu, m_ez;
  logic [31:0] m_cnt;
  logic [63:0] strobe_log[$];

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_phase = P_IDLE;
    m_addr = 64'd0; m_size = 32'd0; m_mode = 1'b0;
    m_cnt = 32'd0; m_eu = 1'b0; m_ez = 1'b0;
  endtask

  // One clock edge of the reference: pop/issue decisions use the queue as it was before the edge.
  task automatic model_step();
    bit    pushed;
    desc_t d;
    pushed = desc_valid && (m_q.size() < DEPTH);
    case (m_phase)
      P_IDLE: begin
        if (m_q.size() != 0) begin
          if (m_q[0].s == 32'd0) begin
            d = m_q.pop_front();
            m_ez = 1'b1;
          end else if (enable) begin
            d = m_q.pop_front();
            m_addr = d.a; m_size = d.s; m_mode = mode;
            m_phase = P_ARM;
          end
        end
        if (buf_done) m_eu = 1'b1;
      end
      P_ARM: begin
        if (buf_done) m_eu = 1'b1;
        m_phase = P_ACT;
      end
      P_ACT: begin
        if (buf_done) begin m_cnt = m_cnt + 32'd1; m_phase = P_IDLE; end
        else if (!enable) m_phase = P_DRAIN;
      end
      default: begin
        if (buf_done) begin m_cnt = m_cnt + 32'd1; m_phase = P_IDLE; end
      end
    endcase
    if (pushed) begin
      d.a = desc_addr; d.s = desc_size;
      m_q.push_back(d);
    end
  endtask

  task automatic compare_all();
    chk("desc_ready", 64'(desc_ready), 64'(m_q.size() < DEPTH));
    chk("fifo_count", 64'(fifo_count), 64'(m_q.size()));
    chk("buf_addr", buf_addr, m_addr);
    chk("buf_size", 64'(buf_size), 64'(m_size));
    chk("write_buf_update", 64'(write_buf_update), 64'(m_phase == P_ARM && !m_mode));
    chk("read_buf_update", 64'(read_buf_update), 64'(m_phase == P_ARM && m_mode));
    chk("busy", 64'(busy), 64'(m_phase != P_IDLE));
    chk("bufs_done_cnt", 64'(bufs_done_cnt), 64'(m_cnt));
    chk("err_unexp_done", 64'(err_unexp_done), 64'(m_eu));
    chk("err_zero_size", 64'(err_zero_size), 64'(m_ez));
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!rstn) model_reset();
    else model_step();
    #1;
    compare_all();
    if (write_buf_update || read_buf_update) strobe_log.push_back(buf_addr);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    enable = 1'b0; mode = 1'b0; desc_valid = 1'b0; buf_done = 1'b0;
    desc_addr = 64'd0; desc_size = 32'd0;
    #1;
    model_reset();
    cycle();
    cycle();
    @(negedge clk);
    rstn = 1'b1;
    strobe_log.delete();
  endtask

  task automatic push(input logic [63:0] a, input logic [31:0] s);
    bit acc;
    acc = 1'b0;
    desc_valid = 1'b1; desc_addr = a; desc_size = s;
    for (int k = 0; k < 20 && !acc; k++) begin
      acc = desc_ready;
      cycle();
    end
    desc_valid = 1'b0;
    chk("push accepted", 64'(acc), 64'd1);
  endtask

  // Completes every issued buffer as soon as it reaches ACTIVE.
  task automatic service(input int ncyc);
    for (int k = 0; k < ncyc; k++) begin
      buf_done = busy && !(write_buf_update || read_buf_update);
      cycle();
    end
    buf_done = 1'b0;
  endtask

  typedef struct {
    logic v; logic [63:0] a; logic [31:0] s; logic dn, en, md;
    logic rdy, wr, rd, bsy; int cnt; logic [63:0] addr; logic [31:0] size; int dcnt;
  } vec_t;
  vec_t tbl[15];

  initial begin
    tbl[0]  = '{1'b1, 64'h1000, 32'd4096, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 64'h0,    32'd0,    0};
    tbl[1]  = '{1'b0, 64'h0,    32'd0,    1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 0, 64'h1000, 32'd4096, 0};
    tbl[2]  = '{1'b0, 64'h0,    32'd0,    1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 64'h1000, 32'd4096, 0};
    tbl[3]  = '{1'b1, 64'h2000, 32'd256,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1, 64'h1000, 32'd4096, 0};
    tbl[4]  = '{1'b1, 64'h3000, 32'd512,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2, 64'h1000, 32'd4096, 0};
    tbl[5]  = '{1'b0, 64'h0,    32'd0,    1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2, 64'h1000, 32'd4096, 1};
    tbl[6]  = '{1'b0, 64'h0,    32'd0,    1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1, 64'h2000, 32'd256,  1};
    tbl[7]  = '{1'b0, 64'h0,    32'd0,    1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1, 64'h2000, 32'd256,  1};
    tbl[8]  = '{1'b0, 64'h0,    32'd0,    1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 64'h2000, 32'd256,  2};
    tbl[9]  = '{1'b0, 64'h0,    32'd0,    1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 0, 64'h3000, 32'd512,  2};
    tbl[10] = '{1'b0, 64'h0,    32'd0,    1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 64'h3000, 32'd512,  2};
    tbl[11] = '{1'b0, 64'h0,    32'd0,    1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 64'h3000, 32'd512,  2};
    tbl[12] = '{1'b0, 64'h0,    32'd0,    1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 64'h3000, 32'd512,  2};
    tbl[13] = '{1'b0, 64'h0,    32'd0,    1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 64'h3000, 32'd512,  3};
    tbl[14] = '{1'b0, 64'h0,    32'd0,    1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 64'h3000, 32'd512,  3};

    // Reset values.
    do_reset();
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset desc_ready", 64'(desc_ready), 64'd1);
    chk("reset fifo_count", 64'(fifo_count), 64'd0);
    chk("reset buf_addr", buf_addr, 64'd0);
    chk("reset strobes", 64'({write_buf_update, read_buf_update}), 64'd0);

    // Directed vector table: issue latency, back-to-back, mode latch, drain.
    for (int i = 0; i < 15; i++) begin
      desc_valid = tbl[i].v; desc_addr = tbl[i].a; desc_size = tbl[i].s;
      buf_done = tbl[i].dn; enable = tbl[i].en; mode = tbl[i].md;
      cycle();
      chk($sformatf("row%0d desc_ready", i), 64'(desc_ready), 64'(tbl[i].rdy));
      chk($sformatf("row%0d write_upd", i), 64'(write_buf_update), 64'(tbl[i].wr));
      chk($sformatf("row%0d read_upd", i), 64'(read_buf_update), 64'(tbl[i].rd));
      chk($sformatf("row%0d busy", i), 64'(busy), 64'(tbl[i].bsy));
      chk($sformatf("row%0d fifo_count", i), 64'(fifo_count), 64'(tbl[i].cnt));
      chk($sformatf("row%0d buf_addr", i), buf_addr, tbl[i].addr);
      chk($sformatf("row%0d buf_size", i), 64'(buf_size), 64'(tbl[i].size));
      chk($sformatf("row%0d done_cnt", i), 64'(bufs_done_cnt), 64'(tbl[i].dcnt));
      chk($sformatf("row%0d errors", i), 64'({err_unexp_done, err_zero_size}), 64'd0);
    end
    desc_valid = 1'b0; buf_done = 1'b0;

    // Full FIFO: fifth descriptor waits for a pop, order preserved.
    do_reset();
    for (int i = 0; i < 4; i++) push(64'hA000 + 64'(i) * 64'h100, 32'(i + 1));
    chk("full fifo_count", 64'(fifo_count), 64'd4);
    chk("full desc_ready", 64'(desc_ready), 64'd0);
    desc_valid = 1'b1; desc_addr = 64'hA400; desc_size = 32'd5;
    for (int k = 0; k < 3; k++) cycle();
    chk("full held fifo_count", 64'(fifo_count), 64'd4);
    enable = 1'b1;
    push(64'hA400, 32'd5);
    service(40);
    chk("full strobes", 64'(strobe_log.size()), 64'd5);
    for (int i = 0; i < 5 && i < strobe_log.size(); i++)
      chk($sformatf("full order%0d", i), strobe_log[i], 64'hA000 + 64'(i) * 64'h100);
    chk("full done_cnt", 64'(bufs_done_cnt), 64'd5);

    // Drain: enable drops in ACTIVE, no reissue while it stays low.
    do_reset();
    enable = 1'b1;
    push(64'hB000, 32'd16); push(64'hB100, 32'd32); push(64'hB200, 32'd48);
    enable = 1'b0;
    cycle();
    chk("drain busy", 64'(busy), 64'd1);
    buf_done = 1'b1; cycle(); buf_done = 1'b0;
    for (int k = 0; k < 5; k++) cycle();
    chk("drain strobes", 64'(strobe_log.size()), 64'd1);
    chk("drain fifo_count", 64'(fifo_count), 64'd2);
    chk("drain busy idle", 64'(busy), 64'd0);
    chk("drain done_cnt", 64'(bufs_done_cnt), 64'd1);

    // Error flags are sticky until reset.
    do_reset();
    buf_done = 1'b1; cycle(); buf_done = 1'b0;
    chk("err_unexp set", 64'(err_unexp_done), 64'd1);
    enable = 1'b1;
    push(64'hC000, 32'd0);
    for (int k = 0; k < 3; k++) cycle();
    chk("err_zero set", 64'(err_zero_size), 64'd1);
    chk("zero popped", 64'(fifo_count), 64'd0);
    chk("zero no strobe", 64'(strobe_log.size()), 64'd0);
    chk("err_unexp sticky", 64'(err_unexp_done), 64'd1);

    // Asynchronous reset mid-ACTIVE with two queued.
    do_reset();
    chk("flags cleared", 64'({err_unexp_done, err_zero_size}), 64'd0);
    enable = 1'b1;
    push(64'hD000, 32'd8); push(64'hD100, 32'd8); push(64'hD200, 32'd8);
    chk("pre-reset fifo_count", 64'(fifo_count), 64'd2);
    rstn = 1'b0;
    #1;
    model_reset();
    compare_all();
    chk("async busy", 64'(busy), 64'd0);
    chk("async fifo_count", 64'(fifo_count), 64'd0);
    chk("async buf_size", 64'(buf_size), 64'd0);
    cycle();
    @(negedge clk);
    rstn = 1'b1;
    strobe_log.delete();
    for (int k = 0; k < 6; k++) cycle();
    chk("post-reset strobes", 64'(strobe_log.size()), 64'd0);

    // Randomized traffic against the reference model.
    do_reset();
    for (int k = 0; k < 2000; k++) begin
      desc_valid = ($urandom_range(0, 1) == 1);
      desc_addr  = {$urandom, $urandom};
      desc_size  = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 65535));
      buf_done   = ($urandom_range(0, 3) == 0);
      enable     = ($urandom_range(0, 9) != 0);
      mode       = ($urandom_range(0, 1) == 1);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
